run_sequencer: RTL

Run controller for the single-cycle core. Sequences one program execution per host request: it holds the core idle, issues a clean core reset, gates PC/register-file/data-memory advancement (free-running or single-step), detects program completion from the program counter, and returns a four-phase handshake with a cycle count. It sits beside the top level, between the testbench or host and the `PC`/`reg_file`/`dat_mem` enables.

---
 rtl/run_seq_pkg.sv | 17 +
 rtl/sat_counter.sv | 34 +++
 rtl/run_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
package run_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    PAUSE,
    FINISH
  } state_e;

  localparam int unsigned D_DEF         = 12;
  localparam int unsigned DONE_ADDR_DEF = 340;
  localparam int unsigned CW_DEF        = 16;
  localparam logic [15:0] WD_LIMIT_DEF  = 16'hFFF0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_sequencer.sv
// Run controller for the single-cycle core: reset, gated advance, completion handshake.
// Optional watchdog compiled in with `define RUN_SEQ_WATCHDOG_EN.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned          D         = D_DEF,
  parameter logic [D-1:0]         DONE_ADDR = D'(DONE_ADDR_DEF),
  parameter int unsigned          CW        = CW_DEF,
  parameter logic [CW-1:0]        WD_LIMIT  = CW'(WD_LIMIT_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          step_mode,
  input  logic          step,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_rst,
  output logic          core_en,
  output logic          busy,
  output logic          ack,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   ack_q, ack_d;
  logic   done_q, done_d;
  logic   timeout_q, timeout_d;
  logic   pause_first_q, pause_first_d;
  logic   at_done;
  logic   wd_hit;
  logic   cnt_clr;
  logic [CW-1:0] cnt;

  assign at_done = (prog_ctr == DONE_ADDR);
  assign cnt_clr = (state_q == CLEAR);

`ifdef RUN_SEQ_WATCHDOG_EN
  // Advance is also withheld once the limit is hit so the count stops exactly there.
  assign wd_hit = (cnt >= WD_LIMIT);
`else
  logic unused_wd_limit;
  assign unused_wd_limit = ^WD_LIMIT;
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    core_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) state_d = CLEAR;
      end
      CLEAR: begin
        done_d    = 1'b0;
        timeout_d = 1'b0;
        state_d   = step_mode ? PAUSE : RUN;
      end
      RUN: begin
        core_en = !at_done && !wd_hit;
        if (at_done) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (wd_hit) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end else if (step_mode) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        // A step arriving in the very cycle PAUSE is entered does not advance the core.
        core_en = step && !pause_first_q && !at_done && !wd_hit;
        if (at_done) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (wd_hit) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end else if (!step_mode) begin
          state_d = RUN;
        end
      end
      FINISH: begin
        if (!req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d        = (state_d == CLEAR) || (state_d == RUN) || (state_d == PAUSE);
    ack_d         = (state_d == FINISH);
    pause_first_d = (state_d == PAUSE) && (state_q != PAUSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      pause_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      pause_first_q <= pause_first_d;
    end
  end

  sat_counter #(
    .W (CW)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (core_en),
    .cnt   (cnt)
  );

  assign core_rst  = reset || (state_q == CLEAR);
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cnt;

endmodule
